// File: rtl/skeleton_stream_driver.sv
// Stream sequencer feeding a filter test skeleton: input FIFO -> skeleton -> output FIFO.
// Optional per-sample latency measurement is enabled by defining SKELETON_STREAM_LAT_MEAS_EN.

module skeleton_stream_fifo #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && pop_ok)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop_ok)  rd_q <= rd_q + PTR_ONE;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// state | meaning
// IDLE  | waiting for EN and a queued sample
// LOAD  | pop input word into DUT_DIN
// START | one-cycle trigger to the skeleton
// WAIT  | waiting for a DUT_RDY rising edge or timeout
// STORE | pushing the result, stalls while the output FIFO is full
module skeleton_stream_driver #(
  parameter int BITWIDTH_SYS = 16,
  parameter int FIFO_AW      = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    CLK_SYS,
  input  logic                    nRST,
  input  logic                    EN,
  input  logic                    WR_EN,
  input  logic [BITWIDTH_SYS-1:0] WR_DATA,
  output logic                    IN_FULL,
  input  logic                    RD_EN,
  output logic [BITWIDTH_SYS-1:0] RD_DATA,
  output logic                    OUT_EMPTY,
  output logic                    DUT_START,
  output logic [BITWIDTH_SYS-1:0] DUT_DIN,
  input  logic [BITWIDTH_SYS-1:0] DUT_DOUT,
  input  logic                    DUT_RDY,
  output logic                    BUSY,
  output logic                    TIMEOUT_ERR,
  output logic [15:0]             LAT_LAST
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE} state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q;
  logic [TW-1:0]           tmo_cnt_q;
  logic                    tmo_err_q;
  logic [BITWIDTH_SYS-1:0] din_q, res_q, rd_data_q;

  logic                    in_pop, out_push, capture, tmo_set, rdy_rise;
  logic [BITWIDTH_SYS-1:0] in_head, out_head;
  logic                    in_empty, out_full;

  skeleton_stream_fifo #(.W(BITWIDTH_SYS), .AW(FIFO_AW)) u_in_fifo (
    .clk_i   (CLK_SYS),
    .rst_n_i (nRST),
    .push_i  (WR_EN),
    .data_i  (WR_DATA),
    .pop_i   (in_pop),
    .head_o  (in_head),
    .full_o  (IN_FULL),
    .empty_o (in_empty)
  );

  skeleton_stream_fifo #(.W(BITWIDTH_SYS), .AW(FIFO_AW)) u_out_fifo (
    .clk_i   (CLK_SYS),
    .rst_n_i (nRST),
    .push_i  (out_push),
    .data_i  (res_q),
    .pop_i   (RD_EN),
    .head_o  (out_head),
    .full_o  (out_full),
    .empty_o (OUT_EMPTY)
  );

  assign rdy_rise = DUT_RDY && !rdy_q;

  always_comb begin
    state_d  = state_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    capture  = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      S_IDLE:  if (!in_empty) state_d = S_LOAD;
      S_LOAD:  begin
        in_pop  = 1'b1;
        state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  begin
        if (rdy_rise) begin
          capture = 1'b1;
          state_d = S_STORE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        // out_full is registered, so a same-cycle host pop frees the slot one cycle later
        if (!out_full) begin
          out_push = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!EN) begin
      state_d  = S_IDLE;
      in_pop   = 1'b0;
      out_push = 1'b0;
      capture  = 1'b0;
      tmo_set  = 1'b0;
    end
  end

  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
      din_q     <= '0;
      res_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= DUT_RDY;
      if (state_q == S_START)
        tmo_cnt_q <= '0;
      else if (state_q == S_WAIT && tmo_cnt_q != TMO_LAST)
        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
      if (!EN)
        tmo_err_q <= 1'b0;
      else if (tmo_set)
        tmo_err_q <= 1'b1;
      if (in_pop)  din_q <= in_head;
      if (capture) res_q <= DUT_DOUT;
      if (RD_EN && !OUT_EMPTY) rd_data_q <= out_head;
    end
  end

`ifdef SKELETON_STREAM_LAT_MEAS_EN
  logic [15:0] lat_cnt_q, lat_last_q;

  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      lat_cnt_q  <= '0;
      lat_last_q <= '0;
    end else begin
      if (state_q == S_START)
        lat_cnt_q <= '0;
      else if (state_q == S_WAIT && lat_cnt_q != 16'hFFFF)
        lat_cnt_q <= lat_cnt_q + 16'd1;
      if (capture)
        lat_last_q <= (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;
    end
  end

  assign LAT_LAST = lat_last_q;
`else
  assign LAT_LAST = '0;
`endif

  assign DUT_START   = (state_q == S_START);
  assign DUT_DIN     = din_q;
  assign RD_DATA     = rd_data_q;
  assign BUSY        = (state_q != S_IDLE);
  assign TIMEOUT_ERR = tmo_err_q;
endmodule

// File: doc/skeleton_stream_driver.md
Name: skeleton_stream_driver

Overview:
- Upstream/downstream sequencer for the on-device filter test skeletons.
- Host writes input samples into an input FIFO. The block presents each sample to the skeleton and issues a one-cycle start trigger.
- It waits for the skeleton's ready edge, then pushes the skeleton's output word into an output FIFO for host readout.
- It reports timeouts and, optionally, the measured per-sample latency.

Parameters:
- BITWIDTH_SYS, 16: width of the device data bus, all data ports.
- FIFO_AW, 4: address width of both FIFOs; depth = 2^FIFO_AW = 16 words each.
- TIMEOUT_CYC, 1024: max cycles in WAIT before abort. Must be ≥ 2.

Ports:
- CLK_SYS  in  1  system clock, all logic on rising edge.
- nRST  in  1  asynchronous active-low reset.
- EN  in  1  sequencer enable.
- WR_EN  in  1  host push into input FIFO.
- WR_DATA  in  BITWIDTH_SYS  sample to push.
- IN_FULL  out  1  input FIFO full.
- RD_EN  in  1  host pop from output FIFO.
- RD_DATA  out  BITWIDTH_SYS  popped result, registered.
- OUT_EMPTY  out  1  output FIFO empty.
- DUT_START  out  1  start pulse to skeleton TRGG_START_CALC.
- DUT_DIN  out  BITWIDTH_SYS  sample to skeleton DATA_IN, registered.
- DUT_DOUT  in  BITWIDTH_SYS  skeleton DATA_OUT.
- DUT_RDY  in  1  skeleton RDY, level.
- BUSY  out  1  FSM not in IDLE.
- TIMEOUT_ERR  out  1  sticky timeout flag.
- LAT_LAST  out  16  cycles from DUT_START to DUT_RDY edge of last completed sample.

Behaviour:
- Reset: all outputs are 0; FSM is IDLE; both FIFOs are empty; OUT_EMPTY=1.
- FIFOs:
  - Synchronous and flags registered.
  - WR_EN while IN_FULL is dropped; no pointer change.
  - RD_EN while OUT_EMPTY is ignored; RD_DATA holds its last value.
  - RD_EN while not empty: RD_DATA shows the oldest word on the next cycle.
  - Simultaneous push and pop on the same FIFO, neither blocked: both occur, occupancy unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
  - Full/empty are distinguished by a count of width FIFO_AW+1.
  - FIFOs operate regardless of EN.
- FSM states: IDLE, LOAD, START, WAIT, STORE.
  - IDLE: go to LOAD when EN=1 and the input FIFO is not empty.
  - LOAD: pop one input word; DUT_DIN takes it next edge; go to START.
  - START: DUT_START=1 for exactly this one cycle; clear the latency counter; go to WAIT.
  - WAIT: increment the cycle counter. A rising edge of DUT_RDY (registered DUT_RDY_d=0, DUT_RDY=1) captures DUT_DOUT into a result register and goes to STORE. If the counter reaches TIMEOUT_CYC first: set TIMEOUT_ERR, discard the sample, go to IDLE.
  - DUT_RDY already high entering WAIT is not an edge; it must fall and rise again.
  - STORE: if the output FIFO is not full, push the result and go to IDLE; otherwise stay in STORE (back-pressure).
  - A host pop in the same cycle does not free the slot until the next cycle.
- Latency: a sample written to an empty input FIFO while IDLE and EN=1 gives DUT_START asserted exactly 3 cycles after the WR_EN edge. That is 1 cycle for the flag, then IDLE→LOAD, LOAD→START.
- EN low in any state: at the next edge the FSM goes to IDLE and DUT_START=0. An in-flight sample is discarded, not re-queued. FIFO contents are kept. TIMEOUT_ERR is cleared while EN=0.
- DUT_DIN holds its value between samples.
- BUSY = (state != IDLE).
- nRST asserted mid-operation: immediate return to reset state; FIFO contents are lost.

Optional Feature:
- Macro SKELETON_STREAM_LAT_MEAS_EN.
- Defined: a 16-bit counter runs in WAIT and saturates at 0xFFFF. On the accepted DUT_RDY edge its value plus 1 loads LAT_LAST. LAT_LAST is unchanged on timeout or abort.
- Undefined: LAT_LAST is tied to 0 and no counter is synthesised. The timeout counter is independent of this feature in both cases.

Test Plan:
- Reset, then 1 sample 0x1234 with the DUT model asserting RDY 5 cycles after start and DOUT=0x0246 -> DUT_START is a single pulse 3 cycles after write, DUT_DIN=0x1234, OUT_EMPTY falls, RD_EN gives RD_DATA=0x0246, LAT_LAST=5 (macro on) / 0 (macro off).
- Burst 16 writes with EN=0 -> IN_FULL=1 after the 16th; a 17th write is dropped. EN=1 then yields exactly 16 results, in order.
- Output back-pressure: no reads, 17 samples -> 16 stored, FSM stalls in STORE with BUSY=1. One RD_EN -> 17th result stored, BUSY=0.
- DUT never raises RDY with TIMEOUT_CYC=20 -> TIMEOUT_ERR=1, no result pushed, FSM back in IDLE. EN low then high -> TIMEOUT_ERR=0.
- DUT_RDY held high from a previous sample -> no capture until it falls and rises. Captured value equals DUT_DOUT at the rising edge.
- EN dropped during WAIT, and separately nRST pulsed mid-WAIT -> first: sample discarded, remaining input FIFO intact; second: both FIFOs empty, all outputs 0.
